// File: rtl/subtractor32_if.sv
// Operand/result bundle for the subtractor32 subtract/compare datapath element.
// The master side drives the operands with their valid qualifier and observes the
// registered result and flags; the slave side is the subtractor itself.
interface subtractor32_if;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic [31:0] Result;
  logic        Cout;
  logic        Ovf;
  logic        Neg;
  logic        Zero;

  modport master (
    output in_valid, A, B,
    input  out_valid, Result, Cout, Ovf, Neg, Zero
  );

  modport slave (
    input  in_valid, A, B,
    output out_valid, Result, Cout, Ovf, Neg, Zero
  );
endinterface

// File: rtl/subtractor32.sv
// subtractor32: registered 32-bit two's-complement subtractor, Result = A - B,
// formed as A + ~B + 1 with a ripple of CLA_BLOCK-wide carry-lookahead groups.
// Flags: Cout (1 = no borrow), Ovf (signed overflow), Neg, Zero.
// Optional macro SUBTRACTOR32_PIPE_EN: splits the adder into two stages (low half,
// then high half plus flags) for latency 2 at full throughput; results are identical.
// Result and flags hold their last value on idle cycles.
module subtractor32 #(
  parameter int CLA_BLOCK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  subtractor32_if.slave  bus
);

  localparam int HALF_W      = 16;
  localparam int GROUPS_HALF = HALF_W / CLA_BLOCK;

  if (CLA_BLOCK != 4 && CLA_BLOCK != 8) begin : g_bad_cla
    $error("subtractor32: CLA_BLOCK must be 4 or 8");
  end

  // One lookahead group: every internal carry is a flat sum of generate/propagate
  // products back to the group carry-in, so carries inside a group do not ripple.
  function automatic logic [CLA_BLOCK:0] cla_group(
    input logic [CLA_BLOCK-1:0] a,
    input logic [CLA_BLOCK-1:0] b,
    input logic                 cin
  );
    logic [CLA_BLOCK-1:0] g;
    logic [CLA_BLOCK-1:0] p;
    logic [CLA_BLOCK-1:0] s;
    logic [CLA_BLOCK:0]   c;
    logic                 term;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CLA_BLOCK; i++) begin
      term = cin;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = term;
      for (int k = 0; k <= i; k++) begin
        term = g[k];
        for (int m = k + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    s = p ^ c[CLA_BLOCK-1:0];
    return {c[CLA_BLOCK], s};
  endfunction

  // 16-bit adder built from lookahead groups with the group carries rippling.
  function automatic logic [HALF_W:0] add_half(
    input logic [HALF_W-1:0] a,
    input logic [HALF_W-1:0] b,
    input logic              cin
  );
    logic [HALF_W-1:0]  s;
    logic               carry;
    logic [CLA_BLOCK:0] grp;
    s     = '0;
    carry = cin;
    for (int gi = 0; gi < GROUPS_HALF; gi++) begin
      grp = cla_group(a[gi*CLA_BLOCK +: CLA_BLOCK], b[gi*CLA_BLOCK +: CLA_BLOCK], carry);
      s[gi*CLA_BLOCK +: CLA_BLOCK] = grp[CLA_BLOCK-1:0];
      carry = grp[CLA_BLOCK];
    end
    return {carry, s};
  endfunction

  // Signed overflow of A - B: operand signs differ and the result sign left A's.
  function automatic logic ovf_f(
    input logic a_msb,
    input logic b_msb,
    input logic r_msb
  );
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  logic        out_valid_d, out_valid_q;
  logic [31:0] result_d, result_q;
  logic        cout_d, cout_q;
  logic        ovf_d, ovf_q;
  logic        neg_d, neg_q;
  logic        zero_d, zero_q;

`ifdef SUBTRACTOR32_PIPE_EN
  logic              vld_p1_d, vld_p1_q;
  logic [HALF_W-1:0] lo_p1_d, lo_p1_q;
  logic              c16_p1_d, c16_p1_q;
  logic [HALF_W-1:0] a_hi_p1_d, a_hi_p1_q;
  logic [HALF_W-1:0] b_hi_p1_d, b_hi_p1_q;
  logic [HALF_W:0]   lo_sum;
  logic [HALF_W:0]   hi_sum;
  logic [31:0]       full_res;

  // Stage 1 next-state: low half of A + ~B + 1, carry into bit 16, upper operands.
  always_comb begin
    lo_sum    = add_half(bus.A[HALF_W-1:0], ~bus.B[HALF_W-1:0], 1'b1);
    vld_p1_d  = bus.in_valid;
    lo_p1_d   = lo_p1_q;
    c16_p1_d  = c16_p1_q;
    a_hi_p1_d = a_hi_p1_q;
    b_hi_p1_d = b_hi_p1_q;
    if (bus.in_valid) begin
      lo_p1_d   = lo_sum[HALF_W-1:0];
      c16_p1_d  = lo_sum[HALF_W];
      a_hi_p1_d = bus.A[31:HALF_W];
      b_hi_p1_d = bus.B[31:HALF_W];
    end
  end

  // ---- stage 1 / stage 2 boundary ----
  // Stage 1 register: reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      lo_p1_q   <= '0;
      c16_p1_q  <= 1'b0;
      a_hi_p1_q <= '0;
      b_hi_p1_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      lo_p1_q   <= lo_p1_d;
      c16_p1_q  <= c16_p1_d;
      a_hi_p1_q <= a_hi_p1_d;
      b_hi_p1_q <= b_hi_p1_d;
    end
  end

  // Stage 2 next-state: high half and all flags; hold outputs when stage 1 is empty.
  always_comb begin
    hi_sum      = add_half(a_hi_p1_q, ~b_hi_p1_q, c16_p1_q);
    full_res    = {hi_sum[HALF_W-1:0], lo_p1_q};
    out_valid_d = vld_p1_q;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    neg_d       = neg_q;
    zero_d      = zero_q;
    if (vld_p1_q) begin
      result_d = full_res;
      cout_d   = hi_sum[HALF_W];
      ovf_d    = ovf_f(a_hi_p1_q[HALF_W-1], b_hi_p1_q[HALF_W-1], full_res[31]);
      neg_d    = full_res[31];
      zero_d   = (full_res == 32'h0);
    end
  end
`else
  logic [HALF_W:0] lo_sum;
  logic [HALF_W:0] hi_sum;
  logic [31:0]     full_res;

  // Single-stage next-state: full 32-bit subtract and flags; hold outputs when idle.
  always_comb begin
    lo_sum      = add_half(bus.A[HALF_W-1:0], ~bus.B[HALF_W-1:0], 1'b1);
    hi_sum      = add_half(bus.A[31:HALF_W], ~bus.B[31:HALF_W], lo_sum[HALF_W]);
    full_res    = {hi_sum[HALF_W-1:0], lo_sum[HALF_W-1:0]};
    out_valid_d = bus.in_valid;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    neg_d       = neg_q;
    zero_d      = zero_q;
    if (bus.in_valid) begin
      result_d = full_res;
      cout_d   = hi_sum[HALF_W];
      ovf_d    = ovf_f(bus.A[31], bus.B[31], full_res[31]);
      neg_d    = full_res[31];
      zero_d   = (full_res == 32'h0);
    end
  end
`endif

  // ---- output register boundary ----
  // Output register: reset clears the valid and every result/flag bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;
  assign bus.Cout      = cout_q;
  assign bus.Ovf       = ovf_q;
  assign bus.Neg       = neg_q;
  assign bus.Zero      = zero_q;

endmodule

// File: tb/tb_subtractor32.sv
// Scoreboard bench for subtractor32: the stimulus process pushes the expected
// response from an arithmetic reference model; a negedge monitor pops and compares
// whenever out_valid is seen, and checks hold/idle behaviour otherwise.
module tb_subtractor32;

`ifdef SUBTRACTOR32_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        neg;
    logic        zero;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  subtractor32_if bus ();

  subtractor32 #(.CLA_BLOCK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  exp_t last;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t zero_exp();
    exp_t e;
    e.res = '0; e.cout = 1'b0; e.ovf = 1'b0; e.neg = 1'b0; e.zero = 1'b0; e.due = 0;
    return e;
  endfunction

  // Reference model: plain unsigned/signed arithmetic on wide integers.
  function automatic exp_t model(logic [31:0] a, logic [31:0] b, int due);
    exp_t   e;
    longint sd;
    longint lim;
    lim    = 64'sd2147483647;
    sd     = longint'($signed(a)) - longint'($signed(b));
    e.res  = a - b;
    e.cout = (a >= b);
    e.ovf  = (sd > lim) || (sd < -lim - 1);
    e.neg  = (sd < 0) ^ e.ovf;
    e.zero = (a == b);
    e.due  = due;
    return e;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    if (act !== req) begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
      n_bad++;
    end
  endtask

  task automatic rst_check(string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
    check({tag, "_Result"},    bus.Result,         32'h0);
    check({tag, "_Cout"},      32'(bus.Cout),      32'h0);
    check({tag, "_Ovf"},       32'(bus.Ovf),       32'h0);
    check({tag, "_Neg"},       32'(bus.Neg),       32'h0);
    check({tag, "_Zero"},      32'(bus.Zero),      32'h0);
  endtask

  // Monitor: compare presented results in order; check hold values on idle cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
          n_bad++;
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("latency_cycle", 32'(cyc),      32'(e.due));
          check("Result",        bus.Result,    e.res);
          check("Cout",          32'(bus.Cout), 32'(e.cout));
          check("Ovf",           32'(bus.Ovf),  32'(e.ovf));
          check("Neg",           32'(bus.Neg),  32'(e.neg));
          check("Zero",          32'(bus.Zero), 32'(e.zero));
          last = e;
        end
      end else begin
        check("idle_out_valid", 32'(bus.out_valid), 32'h0);
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          $display("FAIL missing_output: got out_valid=0 expected 1 (cycle %0d)", cyc);
          n_bad++;
          void'(sb.pop_front());
        end
        check("hold_Result", bus.Result,    last.res);
        check("hold_Cout",   32'(bus.Cout), 32'(last.cout));
        check("hold_Ovf",    32'(bus.Ovf),  32'(last.ovf));
        check("hold_Neg",    32'(bus.Neg),  32'(last.neg));
        check("hold_Zero",   32'(bus.Zero), 32'(last.zero));
      end
    end
  end

  task automatic send(logic [31:0] a, logic [31:0] b);
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    sb.push_back(model(a, b, cyc + LAT));
    n_vec++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    bus.in_valid = 1'b0;
    bus.A        = $urandom;
    bus.B        = $urandom;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    last         = zero_exp();
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;

    #3 rst_check("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    send(32'h0000000A, 32'h00000005);
    send(32'h00000005, 32'h0000000A);
    send(32'h0000000F, 32'h0000000F);
    send(32'hFFFFFFFF, 32'h00000001);
    send(32'h12345678, 32'h87654321);
    send(32'h80000000, 32'h00000001);
    idle(2);
    send(32'hDEADBEEF, 32'h00000000);
    send(32'h00000000, 32'h00000001);
    send(32'h7FFFFFFF, 32'hFFFFFFFF);
    send(32'h00000000, 32'h80000000);
    send(32'h80000000, 32'h80000000);
    idle(3);

    for (int i = 0; i < 5; i++) send($urandom, $urandom);
    idle(3);

    // Asynchronous reset while a result is in flight.
    send($urandom, $urandom);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_check("async_rst");
    sb.delete();
    last = zero_exp();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = a;
        1: b = 32'h0;
        2: ;
        3: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
        default: begin
          a = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'h0} ^ 32'($urandom_range(0, 3));
          b = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'h7FFFFFFF} ^ 32'($urandom_range(0, 3));
        end
      endcase
      send(a, b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(LAT + 3);
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
      n_bad++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/subtractor32.md
Name:
subtractor32

Overview:
- 32-bit two's-complement subtractor computing Result = A - B, with carry-out (no-borrow), overflow, negative and zero flags.
- Inputs are captured with a valid qualifier; outputs are registered.
- Used as the subtract/compare datapath element in the ALU cluster.
- Internally built as a ripple of 4-bit carry-lookahead blocks implementing A + ~B + 1.

Parameters:
- CLA_BLOCK, 4, width of each carry-lookahead group. Must divide 32; legal values are 4 and 8.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, A/B are valid this cycle.
- A, input, 32, minuend.
- B, input, 32, subtrahend.
- out_valid, output, 1, Result/flags valid.
- Result, output, 32, A - B modulo 2^32.
- Cout, output, 1, carry out of A + ~B + 1. 1 means no borrow (A >= B unsigned); 0 means borrow.
- Ovf, output, 1, signed overflow: A[31] != B[31] and Result[31] != A[31].
- Neg, output, 1, equals Result[31].
- Zero, output, 1, 1 when Result == 0.

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n.
- While rst_n = 0: out_valid = 0, Result = 0, Cout = 0, Ovf = 0, Neg = 0, Zero = 0.
- Reset mid-operation discards any in-flight result. Outputs stay at reset values until the first valid input after reset is released.
- Arithmetic:
  - sum[32:0] = {1'b0, A} + {1'b0, ~B} + 1.
  - Result = sum[31:0]; Cout = sum[32].
- Carry structure: each CLA_BLOCK group computes generate/propagate terms and a lookahead carry; group carries ripple between groups. Carry-in to group 0 is constant 1.
- Latency: 1 cycle. When in_valid = 1 at edge N, Result and flags are updated and out_valid = 1 after edge N.
- When in_valid = 0 at an edge:
  - out_valid = 0 after that edge.
  - Result and flags hold their previous values (no toggling on idle cycles).
- No backpressure: a new valid operand pair is accepted every cycle.
- Boundary cases:
  - A == B: Result = 0, Zero = 1, Cout = 1.
  - B = 0: Result = A, Cout = 1.
  - A = 0, B = 1: Result = FFFFFFFF, Cout = 0, Neg = 1.
  - A = 80000000, B = 1: Result = 7FFFFFFF, Ovf = 1.
  - Wrap-around modulo 2^32 always; there is no saturation.

Optional Feature:
- Macro SUBTRACTOR32_PIPE_EN.
- When defined:
  - Two-stage pipeline.
  - Stage 1 computes the low 16 bits and registers the low result, the carry into bit 16, and the upper halves of A and B.
  - Stage 2 computes the high 16 bits and all flags.
  - Latency is 2 cycles; throughput is one operation per cycle.
  - out_valid follows in_valid delayed by 2 cycles.
  - Reset clears both stages' valid bits and all output registers.
- When undefined: single-stage behaviour as above, latency 1.
- Results are bit-identical in both builds.

Test Plan:
- A=0000000A, B=00000005, in_valid=1 -> after latency: Result=00000005, Cout=1, Zero=0, Neg=0, Ovf=0, out_valid=1.
- A=00000005, B=0000000A -> Result=FFFFFFFB, Cout=0, Neg=1, Ovf=0.
- A=0000000F, B=0000000F -> Result=00000000, Zero=1, Cout=1; then A=FFFFFFFF, B=00000001 -> Result=FFFFFFFE, Cout=1, Neg=1.
- A=12345678, B=87654321 -> Result=8ACF1357, Cout=0, Ovf=1, Neg=1; then A=80000000, B=00000001 -> Result=7FFFFFFF, Ovf=1.
- Back-to-back valid inputs for 5 cycles, then in_valid=0 -> one result per cycle in order; out_valid drops after the last; Result holds its last value.
- Assert rst_n=0 asynchronously between clock edges while a result is in flight -> all outputs 0 immediately; no stale out_valid after reset release.
- Repeat all scenarios with SUBTRACTOR32_PIPE_EN defined: identical values at latency 2.
